// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath.
// The controller is the master: it reads opcode and drives every control.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] ALUop;
  logic [1:0] PCControl;
  logic       Call;
  logic [1:0] RegDst;
  logic       ALUSrc1;
  logic       ALUSrc2;
  logic       RegWrite;
  logic       SPWrite;
  logic       MemToOut;
  logic       PCUpdate;
  logic       MemWrite;
  logic       WriteDataSrc;
  logic       SPUpdate;
  logic [1:0] ZControl;
  logic [1:0] ZControlSP;

  modport master (
    input  opcode,
    output ALUop, PCControl, Call, RegDst, ALUSrc1, ALUSrc2, RegWrite,
           SPWrite, MemToOut, PCUpdate, MemWrite, WriteDataSrc, SPUpdate,
           ZControl, ZControlSP
  );

  modport slave (
    output opcode,
    input  ALUop, PCControl, Call, RegDst, ALUSrc1, ALUSrc2, RegWrite,
           SPWrite, MemToOut, PCUpdate, MemWrite, WriteDataSrc, SPUpdate,
           ZControl, ZControlSP
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the stack-capable datapath.
//
//   state | meaning
//   IF    | fetch/dispatch, latch opcode class (illegal ops retire here)
//   EX    | ALU execute for RTYPE/ALUI/LD/ST
//   WB    | register write-back or store, PC+4
//   SPL   | latch SP +/- 4 into ZSP
//   SPW   | write ZSP back to SP
//   ADR   | Z = SP for the stack memory address
//   MEM   | stack memory access
//   JMP   | CALL target load into PC
//   HALT  | parked until reset
//   BR    | branch compare and PC select
//
// Outputs are decoded from the registered state plus the opcode (Moore on a
// stable opcode). Stack states decode against the class latched at IF.
module multicycle_controller #(
  parameter logic [5:0] ALUOP_ADD = 6'd1,
  parameter logic [5:0] OP_HALT   = 6'h3F
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus,
  output logic [3:0]              state,
  output logic                    halted,
  output logic                    illegal
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_EX   = 4'd1,
    S_WB   = 4'd2,
    S_SPL  = 4'd3,
    S_SPW  = 4'd4,
    S_ADR  = 4'd5,
    S_MEM  = 4'd6,
    S_JMP  = 4'd7,
    S_HALT = 4'd8,
    S_BR   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_NONE  = 4'd0,
    C_RTYPE = 4'd1,
    C_ALUI  = 4'd2,
    C_LD    = 4'd3,
    C_ST    = 4'd4,
    C_BR    = 4'd5,
    C_PUSH  = 4'd6,
    C_POP   = 4'd7,
    C_CALL  = 4'd8,
    C_RET   = 4'd9,
    C_HALT  = 4'd10,
    C_ILL   = 4'd11
  } cls_t;

  state_t cur;
  cls_t   cls;
  cls_t   live_cls;

  // Classify the live opcode; the halt opcode wins over any other decode.
  always_comb begin
    live_cls = C_ILL;
    if (bus.opcode == OP_HALT) begin
      live_cls = C_HALT;
    end else begin
      case (bus.opcode)
        6'd0:                   live_cls = C_RTYPE;
        6'd1, 6'd2, 6'd3:       live_cls = C_ALUI;
        6'd4:                   live_cls = C_LD;
        6'd5:                   live_cls = C_ST;
        6'd8, 6'd9, 6'd10, 6'd11: live_cls = C_BR;
        6'd12:                  live_cls = C_PUSH;
        6'd13:                  live_cls = C_POP;
        6'd14:                  live_cls = C_CALL;
        6'd15:                  live_cls = C_RET;
        default:                live_cls = C_ILL;
      endcase
    end
  end

  // State sequencing and class latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_IF;
      cls <= C_NONE;
    end else begin
      case (cur)
        S_IF: begin
          cls <= live_cls;
          case (live_cls)
            C_RTYPE, C_ALUI, C_LD, C_ST: cur <= S_EX;
            C_BR:                        cur <= S_BR;
            C_PUSH, C_CALL:              cur <= S_SPL;
            C_POP, C_RET:                cur <= S_ADR;
            C_HALT:                      cur <= S_HALT;
            default:                     cur <= S_IF;
          endcase
        end
        S_EX:  cur <= S_WB;
        S_WB:  cur <= S_IF;
        S_BR:  cur <= S_IF;
        S_SPL: cur <= S_SPW;
        S_SPW: begin
          case (cls)
            C_PUSH, C_CALL: cur <= S_ADR;
            C_RET:          cur <= S_MEM;
            default:        cur <= S_IF;
          endcase
        end
        S_ADR: cur <= (cls == C_RET) ? S_SPL : S_MEM;
        S_MEM: begin
          case (cls)
            C_CALL:  cur <= S_JMP;
            C_POP:   cur <= S_SPL;
            default: cur <= S_IF;
          endcase
        end
        S_JMP:  cur <= S_IF;
        S_HALT: cur <= S_HALT;
        default: cur <= S_IF;
      endcase
    end
  end

  // Control decode; reset low forces the idle vector without a clock edge.
  always_comb begin
    bus.ALUop        = 6'd0;
    bus.PCControl    = 2'b00;
    bus.Call         = 1'b0;
    bus.RegDst       = 2'd0;
    bus.ALUSrc1      = 1'b0;
    bus.ALUSrc2      = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.SPWrite      = 1'b0;
    bus.MemToOut     = 1'b0;
    bus.PCUpdate     = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.WriteDataSrc = 1'b0;
    bus.SPUpdate     = 1'b0;
    bus.ZControl     = 2'b00;
    bus.ZControlSP   = 2'b00;
    halted           = 1'b0;
    illegal          = 1'b0;
    if (rst) begin
      case (cur)
        S_IF: begin
          if (live_cls == C_ILL) begin
            bus.PCControl = 2'b01;
            illegal       = 1'b1;
          end
        end
        S_EX: begin
          bus.ZControl = 2'b10;
          case (cls)
            C_ALUI: begin
              bus.ALUop   = bus.opcode;
              bus.ALUSrc2 = 1'b1;
            end
            C_LD, C_ST: begin
              bus.ALUop   = ALUOP_ADD;
              bus.ALUSrc2 = 1'b1;
            end
            default: ;
          endcase
        end
        S_WB: begin
          bus.ZControl  = 2'b01;
          bus.PCControl = 2'b01;
          case (cls)
            C_RTYPE: begin
              bus.RegDst   = 2'd2;
              bus.MemToOut = 1'b1;
              bus.RegWrite = 1'b1;
            end
            C_ALUI: begin
              bus.RegDst   = 2'd1;
              bus.MemToOut = 1'b1;
              bus.RegWrite = 1'b1;
            end
            C_LD: begin
              bus.RegDst   = 2'd1;
              bus.RegWrite = 1'b1;
            end
            C_ST: bus.MemWrite = 1'b1;
            default: ;
          endcase
        end
        S_BR: begin
          bus.ALUop     = bus.opcode;
          bus.PCControl = 2'b01;
        end
        S_SPL: begin
          bus.ZControlSP = 2'b10;
          bus.SPUpdate   = (cls == C_POP) || (cls == C_RET);
        end
        S_SPW: begin
          bus.ZControlSP = 2'b01;
          bus.SPWrite    = 1'b1;
          if (cls == C_POP) bus.PCControl = 2'b01;
        end
        S_ADR: begin
          bus.ALUSrc1  = 1'b1;
          bus.ALUSrc2  = 1'b1;
          bus.ALUop    = ALUOP_ADD;
          bus.ZControl = 2'b10;
        end
        S_MEM: begin
          bus.ZControl = 2'b01;
          case (cls)
            C_PUSH: begin
              bus.MemWrite  = 1'b1;
              bus.PCControl = 2'b01;
            end
            C_CALL: begin
              bus.MemWrite     = 1'b1;
              bus.WriteDataSrc = 1'b1;
            end
            C_POP: begin
              bus.RegDst   = 2'd1;
              bus.RegWrite = 1'b1;
            end
            C_RET: begin
              bus.PCUpdate  = 1'b1;
              bus.PCControl = 2'b01;
            end
            default: ;
          endcase
        end
        S_JMP: begin
          bus.Call      = 1'b1;
          bus.PCControl = 2'b01;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its
// cycle-by-cycle script of expected state and control vector.
module tb_multicycle_controller;
  localparam logic [5:0] ALUOP_ADD = 6'd1;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  typedef struct packed {
    logic [3:0] st;
    logic       hl;
    logic       il;
    logic [5:0] aluop;
    logic [1:0] pcc;
    logic       call;
    logic [1:0] regdst;
    logic       s1, s2, rw, spw, m2o, pcu, mw, wds, spu;
    logic [1:0] z, zsp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] state;
  logic       halted;
  logic       illegal;
  int         n_checks;
  int         n_errors;
  vec_t       exp_q[$];

  multicycle_controller_if bus();

  multicycle_controller #(.ALUOP_ADD(ALUOP_ADD), .OP_HALT(OP_HALT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .state(state), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic vec_t obs_v();
    vec_t v;
    v.st = state; v.hl = halted; v.il = illegal;
    v.aluop = bus.ALUop; v.pcc = bus.PCControl; v.call = bus.Call;
    v.regdst = bus.RegDst; v.s1 = bus.ALUSrc1; v.s2 = bus.ALUSrc2;
    v.rw = bus.RegWrite; v.spw = bus.SPWrite; v.m2o = bus.MemToOut;
    v.pcu = bus.PCUpdate; v.mw = bus.MemWrite; v.wds = bus.WriteDataSrc;
    v.spu = bus.SPUpdate; v.z = bus.ZControl; v.zsp = bus.ZControlSP;
    return v;
  endfunction

  function automatic vec_t idle(input logic [3:0] st);
    vec_t v = '0;
    v.st = st;
    return v;
  endfunction

  // Instruction script: the ordered list of cycles each opcode must produce.
  task automatic build_exp(input logic [5:0] op);
    vec_t v;
    vec_t spl, spw, adr;
    exp_q.delete();
    spl = idle(4'd3); spl.zsp = 2'b10; spl.spu = (op == 6'd13) || (op == 6'd15);
    spw = idle(4'd4); spw.zsp = 2'b01; spw.spw = 1'b1;
    adr = idle(4'd5); adr.s1 = 1'b1; adr.s2 = 1'b1; adr.aluop = ALUOP_ADD; adr.z = 2'b10;
    if (op == OP_HALT) begin
      exp_q.push_back(idle(4'd0));
    end else if (op <= 6'd5) begin
      exp_q.push_back(idle(4'd0));
      v = idle(4'd1); v.z = 2'b10;
      v.aluop = (op == 6'd0) ? 6'd0 : (op <= 6'd3) ? op : ALUOP_ADD;
      v.s2 = (op != 6'd0);
      exp_q.push_back(v);
      v = idle(4'd2); v.z = 2'b01; v.pcc = 2'b01;
      if (op == 6'd0) begin v.regdst = 2'd2; v.m2o = 1'b1; v.rw = 1'b1; end
      else if (op <= 6'd3) begin v.regdst = 2'd1; v.m2o = 1'b1; v.rw = 1'b1; end
      else if (op == 6'd4) begin v.regdst = 2'd1; v.rw = 1'b1; end
      else v.mw = 1'b1;
      exp_q.push_back(v);
    end else if (op >= 6'd8 && op <= 6'd11) begin
      exp_q.push_back(idle(4'd0));
      v = idle(4'd9); v.aluop = op; v.pcc = 2'b01;
      exp_q.push_back(v);
    end else if (op == 6'd12) begin
      exp_q.push_back(idle(4'd0));
      exp_q.push_back(spl); exp_q.push_back(spw); exp_q.push_back(adr);
      v = idle(4'd6); v.z = 2'b01; v.mw = 1'b1; v.pcc = 2'b01;
      exp_q.push_back(v);
    end else if (op == 6'd13) begin
      exp_q.push_back(idle(4'd0));
      exp_q.push_back(adr);
      v = idle(4'd6); v.z = 2'b01; v.regdst = 2'd1; v.rw = 1'b1;
      exp_q.push_back(v);
      exp_q.push_back(spl);
      v = spw; v.pcc = 2'b01;
      exp_q.push_back(v);
    end else if (op == 6'd14) begin
      exp_q.push_back(idle(4'd0));
      exp_q.push_back(spl); exp_q.push_back(spw); exp_q.push_back(adr);
      v = idle(4'd6); v.z = 2'b01; v.mw = 1'b1; v.wds = 1'b1;
      exp_q.push_back(v);
      v = idle(4'd7); v.call = 1'b1; v.pcc = 2'b01;
      exp_q.push_back(v);
    end else if (op == 6'd15) begin
      exp_q.push_back(idle(4'd0));
      exp_q.push_back(adr); exp_q.push_back(spl); exp_q.push_back(spw);
      v = idle(4'd6); v.z = 2'b01; v.pcu = 1'b1; v.pcc = 2'b01;
      exp_q.push_back(v);
    end else begin
      v = idle(4'd0); v.pcc = 2'b01; v.il = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  // Called in the low phase; returns in the low phase after the instruction.
  // cut >= 0 drops reset in the middle of that cycle.
  task automatic run_instr(input logic [5:0] op, input int cut);
    vec_t o;
    int pcc_cnt, rw_cnt, spw_cnt, mw_cnt;
    logic [1:0] last_pcc;
    build_exp(op);
    pcc_cnt = 0; rw_cnt = 0; spw_cnt = 0; mw_cnt = 0; last_pcc = 2'b00;
    bus.opcode = op;
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      o = obs_v();
      chk($sformatf("op%0d.c%0d", op, i), {2'b0, o}, {2'b0, exp_q[i]});
      if (o.pcc == 2'b01) pcc_cnt++;
      rw_cnt += int'(o.rw); spw_cnt += int'(o.spw); mw_cnt += int'(o.mw);
      last_pcc = o.pcc;
      if (i == cut) begin
        #1 rst = 1'b0;
        #1 chk($sformatf("op%0d.rst_now", op), {2'b0, obs_v()}, {2'b0, idle(4'd0)});
        @(posedge clk);
        #1 chk($sformatf("op%0d.rst_hold", op), {2'b0, obs_v()}, {2'b0, idle(4'd0)});
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    chk($sformatf("op%0d.pc_once", op), pcc_cnt, 1);
    chk($sformatf("op%0d.pc_last", op), {30'd0, last_pcc}, 32'd1);
    chk($sformatf("op%0d.wr_once", op),
        {29'd0, rw_cnt <= 1, spw_cnt <= 1, mw_cnt <= 1}, 32'd7);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 9))
      0: return 6'd0;
      1: return 6'($urandom_range(1, 3));
      2: return 6'd4;
      3: return 6'd5;
      4: return 6'($urandom_range(8, 11));
      5: return 6'd12;
      6: return 6'd13;
      7: return 6'd14;
      8: return 6'd15;
      default: return ($urandom_range(0, 3) == 0) ? 6'($urandom_range(6, 7))
                                                   : 6'($urandom_range(16, 62));
    endcase
  endfunction

  initial begin
    logic [5:0] op;
    int len;
    n_checks = 0;
    n_errors = 0;
    bus.opcode = 6'd20;
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rst.idle", {2'b0, obs_v()}, {2'b0, idle(4'd0)});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk($sformatf("rst.hold%0d", k), {2'b0, obs_v()}, {2'b0, idle(4'd0)});
      bus.opcode = 6'($urandom_range(0, 63));
      #1 chk($sformatf("rst.hold%0d.op", k), {2'b0, obs_v()}, {2'b0, idle(4'd0)});
    end
    @(negedge clk);
    rst = 1'b1;

    run_instr(6'd0, -1);
    run_instr(6'd14, -1);
    run_instr(6'd15, -1);
    run_instr(6'd20, -1);
    run_instr(6'd12, -1);
    run_instr(6'd13, -1);
    run_instr(6'd2, -1);
    run_instr(6'd9, -1);

    for (int n = 0; n < 80; n++) begin
      op = pick_op();
      build_exp(op);
      len = exp_q.size();
      run_instr(op, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1);
    end

    run_instr(6'd12, 2);
    run_instr(6'd5, -1);
    run_instr(6'd0, -1);
    run_instr(6'd12, -1);

    bus.opcode = OP_HALT;
    #1 chk("halt.if", {2'b0, obs_v()}, {2'b0, idle(4'd0)});
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 chk($sformatf("halt.c%0d", k), {2'b0, obs_v()}, {2'b0, idle(4'd8) | 30'(1) << 25});
      bus.opcode = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("halt.rst", {2'b0, obs_v()}, {2'b0, idle(4'd0)});
    @(negedge clk);
    rst = 1'b1;
    run_instr(6'd0, -1);
    run_instr(6'd14, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
